// File: rtl/sop_pkg.sv
// rtl/sop_pkg.sv - shared mode encodings and debounce default for the SOP debounce unit
// Contents: sop_mode_e (debounced MODE pair encodings), DEB_CYCLES_DEFAULT.
package sop_pkg;

  typedef enum logic [1:0] {
    MODE_AND_OR  = 2'b00,  // OR of pair products
    MODE_OR_AND  = 2'b01,  // AND of pair sums
    MODE_XOR     = 2'b10,  // XOR of pair products
    MODE_NAND_OR = 2'b11   // inverted OR of pair products
  } sop_mode_e;

  // 10 ms at 50 MHz
  localparam int DEB_CYCLES_DEFAULT = 500000;

endpackage

// File: rtl/sop_debounce_unit_sw_debounce.sv
// rtl/sop_debounce_unit_sw_debounce.sv - one-bit 2-flop synchroniser plus stable-count debouncer
// Ports: i_clk clock, i_rst sync active-high reset, i_sw raw switch,
//        o_deb debounced value, o_busy debounce counter nonzero.
module sw_debounce
  import sop_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sw,
  output logic o_deb,
  output logic o_busy
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  // Loading happens on the cycle the count would reach DEB_CYCLES, so the
  // counter itself never holds DEB_CYCLES and cannot wrap.
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_sw;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/sop_debounce_unit.sv
// rtl/sop_debounce_unit.sv - debounced switch pairs combined by a selectable sum-of-products mode
// Ports: CLOCK_50 clock, RESET sync active-high reset,
//        SW[2*PAIRS+1:0] raw switches (pair k = SW[2k+1:2k], MODE = top two bits),
//        LEDR[0] result, LEDR[1] all-settled flag, LEDR[CNT_W+1:2] result rising-edge count.
// Optional: SOP_EDGE_COUNT_EN enables the edge counter; otherwise LEDR[CNT_W+1:2] is 0.
module sop_debounce_unit
  import sop_pkg::*;
#(
  parameter int PAIRS      = 2,
  parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT,
  parameter int CNT_W      = 4
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET,
  input  logic [2*PAIRS+1:0]   SW,
  output logic [CNT_W+1:0]     LEDR
);

  localparam int NB = 2 * PAIRS + 2;

  logic [NB-1:0] w_deb;
  logic [NB-1:0] w_busy;
  sop_mode_e     w_mode;
  logic          w_or_p;
  logic          w_and_s;
  logic          w_xor_p;
  logic          w_result;
  logic          r_result;
  logic          r_settled;

  for (genvar g = 0; g < NB; g++) begin : g_deb
    sw_debounce #(
      .DEB_CYCLES(DEB_CYCLES)
    ) u_deb (
      .i_clk (CLOCK_50),
      .i_rst (RESET),
      .i_sw  (SW[g]),
      .o_deb (w_deb[g]),
      .o_busy(w_busy[g])
    );
  end

  assign w_mode = sop_mode_e'(w_deb[NB-1:NB-2]);

  always_comb begin
    w_or_p  = 1'b0;
    w_and_s = 1'b1;
    w_xor_p = 1'b0;
    for (int k = 0; k < PAIRS; k++) begin
      w_or_p  = w_or_p  | (w_deb[2*k] & w_deb[2*k+1]);
      w_and_s = w_and_s & (w_deb[2*k] | w_deb[2*k+1]);
      w_xor_p = w_xor_p ^ (w_deb[2*k] & w_deb[2*k+1]);
    end
    case (w_mode)
      MODE_AND_OR:  w_result = w_or_p;
      MODE_OR_AND:  w_result = w_and_s;
      MODE_XOR:     w_result = w_xor_p;
      MODE_NAND_OR: w_result = ~w_or_p;
      default:      w_result = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_result  <= 1'b0;
      r_settled <= 1'b1;
    end else begin
      r_result  <= w_result;
      r_settled <= ~|w_busy;
    end
  end

`ifdef SOP_EDGE_COUNT_EN
  logic             r_prev;
  logic [CNT_W-1:0] r_edge_cnt;

  // Counts rising edges of the registered result; wraps naturally.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      r_prev     <= 1'b0;
      r_edge_cnt <= '0;
    end else begin
      r_prev <= r_result;
      if (r_result && !r_prev) r_edge_cnt <= r_edge_cnt + 1'b1;
    end
  end

  assign LEDR = {r_edge_cnt, r_settled, r_result};
`else
  assign LEDR = {{CNT_W{1'b0}}, r_settled, r_result};
`endif

endmodule

// File: tb/tb_sop_debounce_unit.sv
// tb/tb_sop_debounce_unit.sv - self-checking bench for sop_debounce_unit
module tb_sop_debounce_unit;

  localparam int PAIRS = 2;
  localparam int DEB   = 4;
  localparam int CNT_W = 4;
  localparam int NB    = 2 * PAIRS + 2;
`ifdef SOP_EDGE_COUNT_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NB-1:0]    sw  = '0;
  logic [CNT_W+1:0] ledr;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference state: raw samples seen at the last two edges, accepted values,
  // and how many consecutive synchronised samples have disagreed with them.
  bit         m_h1 [NB];
  bit         m_h2 [NB];
  bit         m_d  [NB];
  int         m_run[NB];
  bit         m_led0;
  bit         m_settled;
  bit         m_prev;
  int         m_cnt;

  sop_debounce_unit #(
    .PAIRS(PAIRS), .DEB_CYCLES(DEB), .CNT_W(CNT_W)
  ) dut (
    .CLOCK_50(clk), .RESET(rst), .SW(sw), .LEDR(ledr)
  );

  always #5 clk = ~clk;

  function automatic bit mode_fn();
    bit any_p = 0, all_s = 1, par_p = 0;
    int mode;
    for (int k = 0; k < PAIRS; k++) begin
      any_p = any_p | (m_d[2*k] & m_d[2*k+1]);
      all_s = all_s & (m_d[2*k] | m_d[2*k+1]);
      par_p = par_p ^ (m_d[2*k] & m_d[2*k+1]);
    end
    mode = 2 * m_d[NB-1] + m_d[NB-2];
    if (mode == 0) return any_p;
    if (mode == 1) return all_s;
    if (mode == 2) return par_p;
    return !any_p;
  endfunction

  function automatic logic [CNT_W+1:0] model_ledr();
    logic [CNT_W-1:0] c;
    c = EDGE_EN ? CNT_W'(m_cnt) : '0;
    return {c, m_settled, m_led0};
  endfunction

  task automatic model_update();
    bit new_led0, all_quiet;
    if (rst) begin
      for (int b = 0; b < NB; b++) begin
        m_h1[b] = 0; m_h2[b] = 0; m_d[b] = 0; m_run[b] = 0;
      end
      m_led0 = 0; m_settled = 1; m_prev = 0; m_cnt = 0;
      return;
    end
    new_led0  = mode_fn();
    all_quiet = 1;
    for (int b = 0; b < NB; b++) if (m_run[b] != 0) all_quiet = 0;
    if (m_led0 && !m_prev) m_cnt = (m_cnt + 1) % (1 << CNT_W);
    m_prev    = m_led0;
    m_led0    = new_led0;
    m_settled = all_quiet;
    for (int b = 0; b < NB; b++) begin
      if (m_h2[b] == m_d[b]) m_run[b] = 0;
      else if (m_run[b] + 1 == DEB) begin m_d[b] = m_h2[b]; m_run[b] = 0; end
      else m_run[b] = m_run[b] + 1;
      m_h2[b] = m_h1[b];
      m_h1[b] = sw[b];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("ledr_model", 32'(ledr), 32'(model_ledr()));
  endtask

  task automatic hold(input int n);
    repeat (n) step();
  endtask

  task automatic do_reset(input logic [NB-1:0] v);
    rst = 1'b1;
    sw  = v;
    hold(3);
    rst = 1'b0;
  endtask

  initial begin
    bit seen_low, seen_high;

    // Reset state and first post-release evaluation
    do_reset('0);
    chk("reset_ledr", 32'(ledr), 32'h02);
    step();
    chk("post_reset_ledr", 32'(ledr), 32'h02);
    hold(4);

    // AND-OR: pair 0 high -> result 7 cycles after the change
    sw = 6'b000011;
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("andor_before", 32'(ledr[0]), 32'd0);
    end
    step();
    chk("andor_at7", 32'(ledr[0]), 32'd1);
    hold(3);
    chk("andor_count", 32'(ledr[5:2]), 32'(EDGE_EN ? 1 : 0));
    sw = 6'b001100;
    seen_low = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (ledr[0] !== 1'b1) seen_low = 1;
    end
    chk("andor_swap_held", 32'(seen_low), 32'd0);

    // Glitch rejection on SW[0] while SW[1] is held high
    sw = 6'b000010;
    hold(12);
    sw = 6'b000011;
    hold(3);
    sw = 6'b000010;
    seen_high = 0;
    seen_low  = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (ledr[0] !== 1'b0) seen_high = 1;
      if (ledr[1] === 1'b0) seen_low = 1;
    end
    chk("glitch_result", 32'(seen_high), 32'd0);
    chk("glitch_busy", 32'(seen_low), 32'd1);
    chk("glitch_settled", 32'(ledr[1]), 32'd1);

    // All four modes with SW[3:0]=0101
    for (int m = 0; m < 4; m++) begin
      logic [1:0] mv;
      mv = 2'(m);
      sw = {mv, 4'b0101};
      hold(12);
      chk($sformatf("mode_%0d", m), 32'(ledr[0]), 32'(m % 2));
    end

    // Edge counter wrap
    do_reset('0);
    hold(4);
    for (int i = 1; i <= 16; i++) begin
      sw = 6'b000011;
      hold(10);
      if (i == 15) chk("wrap_15", 32'(ledr[5:2]), 32'(EDGE_EN ? 15 : 0));
      if (i == 16) chk("wrap_0", 32'(ledr[5:2]), 32'd0);
      sw = 6'b000000;
      hold(10);
    end

    // Reset in the middle of a debounce
    do_reset('0);
    hold(4);
    sw = 6'b000011;
    hold(4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("midreset_abandon", 32'(ledr[0]), 32'd0);
    end
    hold(6);
    chk("midreset_accept", 32'(ledr[0]), 32'd1);

    // Randomised segments with occasional resets
    for (int seg = 0; seg < 300; seg++) begin
      sw = NB'($urandom);
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1;
        hold($urandom_range(1, 3));
        rst = 1'b0;
      end
      hold($urandom_range(1, 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
